// File: rtl/ni_packetizer.sv
// ni_packetizer: network-interface transmit stage. Buffers one packet of PE
// payload beats store-and-forward, then emits a header flit followed by the
// payload flits on an AXI-stream link toward the local router port.
module ni_packetizer #(
    parameter int PORT_WIDTH = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int ADR_WIDTH  = 4,
    parameter int LOCAL_ADR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PORT_WIDTH-1:0] wr_data,
    input  logic [ADR_WIDTH-1:0]  wr_dest,
    input  logic                  wr_last,
    output logic                  tvalid,
    input  logic                  tready,
    output logic [PORT_WIDTH-1:0] tdata,
    output logic                  tlast,
    output logic                  err_trunc,
    output logic [15:0]           pkt_count
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] DEPTH_8 = 8'(FIFO_DEPTH);
    localparam logic [ADR_WIDTH-1:0] SRC_ADR = ADR_WIDTH'(LOCAL_ADR);

    typedef enum logic [1:0] {
        S_FILL,
        S_HDR,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            rd_ptr_q, rd_ptr_d;
    logic [7:0]            seq_q, seq_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [ADR_WIDTH-1:0]  dest_q, dest_d;
    logic                  err_trunc_q, err_trunc_d;
    logic [PORT_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  wr_fire;
    logic                  t_fire;
    logic                  fill_full;
    logic [PORT_WIDTH-1:0] header;

    // Output flit and handshakes are derived only from registered state.
    always_comb begin
        header = '0;
        header[PORT_WIDTH-1 -: ADR_WIDTH]             = dest_q;
        header[PORT_WIDTH-ADR_WIDTH-1 -: ADR_WIDTH]   = SRC_ADR;
        header[PORT_WIDTH-2*ADR_WIDTH-1 -: 8]         = count_q;
        header[PORT_WIDTH-2*ADR_WIDTH-9 -: 8]         = seq_q;

        wr_ready  = (state_q == S_FILL) && !rst;
        tvalid    = (state_q != S_FILL);
        tlast     = (state_q == S_DRAIN) && (rd_ptr_q == count_q - 8'd1);
        tdata     = '0;
        if (state_q == S_HDR) begin
            tdata = header;
        end else if (state_q == S_DRAIN) begin
            tdata = mem_q[rd_ptr_q[IDX_W-1:0]];
        end

        wr_fire   = wr_valid && wr_ready;
        t_fire    = tvalid && tready;
        fill_full = (count_q + 8'd1 == DEPTH_8);
        err_trunc = err_trunc_q;
        pkt_count = pkt_count_q;
    end

    // Next-state logic: fill the buffer, send the header, then drain payload.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        seq_d       = seq_q;
        pkt_count_d = pkt_count_q;
        dest_d      = dest_q;
        err_trunc_d = 1'b0;

        unique case (state_q)
            S_FILL: begin
                if (wr_fire) begin
                    if (count_q == 8'd0) begin
                        dest_d = wr_dest;
                    end
                    count_d = count_q + 8'd1;
                    if (wr_last || fill_full) begin
                        state_d = S_HDR;
                    end
                    err_trunc_d = fill_full && !wr_last;
                end
            end
            S_HDR: begin
                if (t_fire) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (t_fire) begin
                    if (tlast) begin
                        count_d     = 8'd0;
                        rd_ptr_d    = 8'd0;
                        seq_d       = seq_q + 8'd1;
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = S_FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Control registers; reset discards any partially buffered packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            count_q     <= 8'd0;
            rd_ptr_q    <= 8'd0;
            seq_q       <= 8'd0;
            pkt_count_q <= 16'd0;
            dest_q      <= '0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            seq_q       <= seq_d;
            pkt_count_q <= pkt_count_d;
            dest_q      <= dest_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    // Payload storage; contents are only read back once count covers them.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[count_q[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed testbench for ni_packetizer with hand-computed expected flits.
module tb_ni_packetizer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [127:0] wr_data;
    logic [3:0]   wr_dest;
    logic         wr_last;
    logic         tvalid;
    logic         tready;
    logic [127:0] tdata;
    logic         tlast;
    logic         err_trunc;
    logic [15:0]  pkt_count;

    int check_cnt = 0;
    int pass_cnt  = 0;

    ni_packetizer #(
        .PORT_WIDTH(128),
        .FIFO_DEPTH(16),
        .ADR_WIDTH (4),
        .LOCAL_ADR (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_dest  (wr_dest),
        .wr_last  (wr_last),
        .tvalid   (tvalid),
        .tready   (tready),
        .tdata    (tdata),
        .tlast    (tlast),
        .err_trunc(err_trunc),
        .pkt_count(pkt_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Header layout: dest, source (0), length, seq, zero padding.
    function automatic logic [127:0] hdr(input logic [3:0] d, input logic [7:0] len,
                                         input logic [7:0] sq);
        return {d, 4'h0, len, sq, 104'h0};
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs,
                                input logic [127:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Offer one beat in FILL; it is taken on the next rising edge.
    task automatic apply_stimulus(input logic [3:0] d, input logic [127:0] data,
                                  input logic last);
        wr_valid = 1'b1;
        wr_dest  = d;
        wr_data  = data;
        wr_last  = last;
        #1;
        check_output("wr_ready_fill", {127'd0, wr_ready}, 128'd1);
        check_output("err_trunc_idle", {127'd0, err_trunc}, 128'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Wait (bounded) for a flit, check it, and let it handshake.
    task automatic expect_flit(input string tag, input logic [127:0] exp_data,
                               input logic exp_last);
        int waited = 0;
        tready = 1'b1;
        while (!tvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, "_valid"}, {127'd0, tvalid}, 128'd1);
        check_output({tag, "_data"}, tdata, exp_data);
        check_output({tag, "_last"}, {127'd0, tlast}, {127'd0, exp_last});
        @(negedge clk);
    endtask

    logic [127:0] exp4 [5];

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_dest  = '0;
        wr_last  = 1'b0;
        tready   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_wr_ready", {127'd0, wr_ready}, 128'd0);
        check_output("rst_tvalid", {127'd0, tvalid}, 128'd0);
        check_output("rst_tlast", {127'd0, tlast}, 128'd0);
        check_output("rst_tdata", tdata, 128'd0);
        check_output("rst_err_trunc", {127'd0, err_trunc}, 128'd0);
        check_output("rst_pkt_count", {112'd0, pkt_count}, 128'd0);
        rst = 1'b0;
        #1;
        check_output("post_rst_wr_ready", {127'd0, wr_ready}, 128'd1);
        check_output("post_rst_tvalid", {127'd0, tvalid}, 128'd0);

        // Single-beat packet with exact latency
        tready = 1'b1;
        apply_stimulus(4'd3, 128'hA5, 1'b1);
        check_output("p0_hdr_valid", {127'd0, tvalid}, 128'd1);
        check_output("p0_hdr_data", tdata, hdr(4'd3, 8'd1, 8'd0));
        check_output("p0_hdr_last", {127'd0, tlast}, 128'd0);
        check_output("p0_hdr_wr_ready", {127'd0, wr_ready}, 128'd0);
        @(negedge clk);
        check_output("p0_flit_valid", {127'd0, tvalid}, 128'd1);
        check_output("p0_flit_data", tdata, 128'hA5);
        check_output("p0_flit_last", {127'd0, tlast}, 128'd1);
        @(negedge clk);
        check_output("p0_done_tvalid", {127'd0, tvalid}, 128'd0);
        check_output("p0_pkt_count", {112'd0, pkt_count}, 128'd1);

        // Four-beat packet drained with tready toggling
        for (int i = 1; i <= 4; i++) apply_stimulus(4'd5, 128'(i), (i == 4));
        exp4[0] = hdr(4'd5, 8'd4, 8'd1);
        for (int i = 1; i <= 4; i++) exp4[i] = 128'(i);
        for (int i = 0; i < 5; i++) begin
            tready = 1'b0;
            check_output("p1_stall_valid", {127'd0, tvalid}, 128'd1);
            check_output("p1_stall_data", tdata, exp4[i]);
            check_output("p1_stall_last", {127'd0, tlast}, {127'd0, (i == 4)});
            @(negedge clk);
            tready = 1'b1;
            check_output("p1_hold_data", tdata, exp4[i]);
            check_output("p1_hold_last", {127'd0, tlast}, {127'd0, (i == 4)});
            @(negedge clk);
        end
        check_output("p1_done_tvalid", {127'd0, tvalid}, 128'd0);
        check_output("p1_pkt_count", {112'd0, pkt_count}, 128'd2);

        // Twenty beats: forced close at 16, then a 4-beat packet
        for (int i = 1; i <= 16; i++)
            apply_stimulus((i == 1) ? 4'd7 : 4'd8, 128'(100 + i), 1'b0);
        check_output("trunc_pulse", {127'd0, err_trunc}, 128'd1);
        expect_flit("trunc_hdr", hdr(4'd7, 8'd16, 8'd2), 1'b0);
        check_output("trunc_pulse_once", {127'd0, err_trunc}, 128'd0);
        for (int i = 1; i <= 16; i++)
            expect_flit("trunc_flit", 128'(100 + i), (i == 16));
        for (int i = 17; i <= 20; i++)
            apply_stimulus((i == 17) ? 4'd9 : 4'd2, 128'(200 + i), (i == 20));
        expect_flit("p3_hdr", hdr(4'd9, 8'd4, 8'd3), 1'b0);
        for (int i = 17; i <= 20; i++)
            expect_flit("p3_flit", 128'(200 + i), (i == 20));
        check_output("p3_err_trunc", {127'd0, err_trunc}, 128'd0);
        check_output("p3_pkt_count", {112'd0, pkt_count}, 128'd4);

        // wr_valid held through HDR/DRAIN
        apply_stimulus(4'd1, 128'h11, 1'b0);
        apply_stimulus(4'd1, 128'h22, 1'b1);
        wr_valid = 1'b1;
        wr_dest  = 4'd6;
        wr_data  = 128'h33;
        wr_last  = 1'b1;
        check_output("held_hdr_wr_ready", {127'd0, wr_ready}, 128'd0);
        check_output("held_hdr_data", tdata, hdr(4'd1, 8'd2, 8'd4));
        @(negedge clk);
        check_output("held_f0_wr_ready", {127'd0, wr_ready}, 128'd0);
        check_output("held_f0_data", tdata, 128'h11);
        @(negedge clk);
        check_output("held_f1_wr_ready", {127'd0, wr_ready}, 128'd0);
        check_output("held_f1_data", tdata, 128'h22);
        check_output("held_f1_last", {127'd0, tlast}, 128'd1);
        @(negedge clk);
        check_output("held_fill_wr_ready", {127'd0, wr_ready}, 128'd1);
        check_output("held_fill_tvalid", {127'd0, tvalid}, 128'd0);
        check_output("held_pkt_count", {112'd0, pkt_count}, 128'd5);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        expect_flit("held_next_hdr", hdr(4'd6, 8'd1, 8'd5), 1'b0);
        expect_flit("held_next_flit", 128'h33, 1'b1);
        check_output("held_next_pkt_count", {112'd0, pkt_count}, 128'd6);

        // Reset asserted for three cycles mid-DRAIN
        apply_stimulus(4'd2, 128'hB1, 1'b0);
        apply_stimulus(4'd2, 128'hB2, 1'b0);
        apply_stimulus(4'd2, 128'hB3, 1'b1);
        expect_flit("mid_hdr", hdr(4'd2, 8'd3, 8'd6), 1'b0);
        expect_flit("mid_flit0", 128'hB1, 1'b0);
        tready = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_output("mid_rst_tvalid", {127'd0, tvalid}, 128'd0);
        check_output("mid_rst_tdata", tdata, 128'd0);
        check_output("mid_rst_pkt_count", {112'd0, pkt_count}, 128'd0);
        check_output("mid_rst_wr_ready", {127'd0, wr_ready}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("mid_post_wr_ready", {127'd0, wr_ready}, 128'd1);
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("mid_no_stray", {127'd0, tvalid}, 128'd0);
        end

        // 256 one-beat packets: seq runs 0..255 then wraps
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(4'(i), 128'(i + 1000), 1'b1);
            expect_flit("burst_hdr", hdr(4'(i), 8'd1, 8'(i)), 1'b0);
            expect_flit("burst_flit", 128'(i + 1000), 1'b1);
        end
        check_output("burst_pkt_count", {112'd0, pkt_count}, 128'd256);
        apply_stimulus(4'd4, 128'hEE, 1'b1);
        expect_flit("wrap_hdr", hdr(4'd4, 8'd1, 8'd0), 1'b0);
        expect_flit("wrap_flit", 128'hEE, 1'b1);
        check_output("wrap_pkt_count", {112'd0, pkt_count}, 128'd257);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
